// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings, FSM states
// and the alignment rule applied to every request.
package lsu_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_D = 2'b11;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    STORE_RD = 3'd2,
    STORE_WR = 3'd3,
    RESP     = 3'd4
  } lsu_state_t;

  // An access is misaligned when any address bit below its natural size is set.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
    logic mis;
    mis = 1'b0;
    case (size)
      SIZE_B:  mis = 1'b0;
      SIZE_H:  mis = off[0];
      SIZE_W:  mis = |off[1:0];
      default: mis = |off;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane datapath: extracts and extends load data from a memory word, and
// merges right-justified store data into the addressed lanes of a word.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic [1:0]            size,
  input  logic [2:0]            offset,
  input  logic                  is_unsigned,
  input  logic [DATA_WIDTH-1:0] rd_word,
  input  logic [DATA_WIDTH-1:0] merge_word,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic [DATA_WIDTH-1:0] store_data
);

  logic [5:0]            shamt;
  logic [DATA_WIDTH-1:0] shifted_rd;
  logic [DATA_WIDTH-1:0] shifted_wd;
  logic [7:0]            lane_mask;

  assign shamt      = {offset, 3'b000};
  assign shifted_rd = rd_word >> shamt;
  assign shifted_wd = wdata << shamt;

  always_comb begin
    load_data = '0;
    case (size)
      SIZE_B:  load_data = {{(DATA_WIDTH-8){~is_unsigned & shifted_rd[7]}}, shifted_rd[7:0]};
      SIZE_H:  load_data = {{(DATA_WIDTH-16){~is_unsigned & shifted_rd[15]}}, shifted_rd[15:0]};
      SIZE_W:  load_data = {{(DATA_WIDTH-32){~is_unsigned & shifted_rd[31]}}, shifted_rd[31:0]};
      default: load_data = shifted_rd;
    endcase
  end

  always_comb begin
    lane_mask = 8'hFF;
    case (size)
      SIZE_B:  lane_mask = 8'h01 << offset;
      SIZE_H:  lane_mask = 8'h03 << offset;
      SIZE_W:  lane_mask = 8'h0F << offset;
      default: lane_mask = 8'hFF;
    endcase
  end

  // A double store covers all lanes, so the merge word drops out entirely.
  always_comb begin
    store_data = merge_word;
    for (int i = 0; i < 8; i++) begin
      if (lane_mask[i]) store_data[8*i +: 8] = shifted_wd[8*i +: 8];
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit in front of a word-wide data memory;
// sub-word stores are done as read-modify-write of the containing word.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH+2:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_write,
  output logic                  mem_read,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic [2:0]            dbg_state
);

  lsu_state_t            state, state_nx;
  logic                  write_q, unsigned_q, err_q;
  logic [1:0]            size_q;
  logic [ADDR_WIDTH+2:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q, merge_q;
  logic [DATA_WIDTH-1:0] load_data, store_data;
  logic                  accept;

  // Request handshake: a request transfers on a rising edge where
  // req_valid && req_ready; ready is high only in IDLE, and the request fields
  // are sampled on that edge alone and ignored until the next transfer.
  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (is_misaligned(req_size, req_addr[2:0])) state_nx = RESP;
          else if (!req_write)                        state_nx = LOAD;
          else if (req_size == SIZE_D)                state_nx = STORE_WR;
          else                                        state_nx = STORE_RD;
        end
      end
      LOAD:     state_nx = RESP;
      STORE_RD: state_nx = STORE_WR;
      STORE_WR: state_nx = RESP;
      RESP:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      write_q    <= 1'b0;
      unsigned_q <= 1'b0;
      err_q      <= 1'b0;
      size_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      merge_q    <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        write_q    <= req_write;
        unsigned_q <= req_unsigned;
        size_q     <= req_size;
        addr_q     <= req_addr;
        wdata_q    <= req_wdata;
        err_q      <= is_misaligned(req_size, req_addr[2:0]);
        rdata_q    <= '0;
        merge_q    <= '0;
      end
      if (state == LOAD)     rdata_q <= load_data;
      if (state == STORE_RD) merge_q <= mem_read_data;
    end
  end

  lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .size        (size_q),
    .offset      (addr_q[2:0]),
    .is_unsigned (unsigned_q),
    .rd_word     (mem_read_data),
    .merge_word  (merge_q),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .store_data  (store_data)
  );

  assign mem_addr       = addr_q[ADDR_WIDTH+2:3];
  assign mem_read       = (state == LOAD) || (state == STORE_RD);
  assign mem_write      = (state == STORE_WR);
  assign mem_write_data = (state == STORE_WR) ? store_data : '0;
  assign resp_valid     = (state == RESP);
  // rdata_q stays zero for stores and errors since it is cleared on acceptance.
  assign resp_rdata     = (state == RESP) ? rdata_q : '0;
  assign resp_err       = (state == RESP) && err_q;
  assign dbg_state      = state;

  logic unused_write_q;
  assign unused_write_q = write_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases with literal expectations, then
// randomized requests checked every cycle against a byte-level reference model.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [12:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic [9:0]  mem_addr;
  logic [63:0] mem_write_data;
  logic        mem_write;
  logic        mem_read;
  logic [63:0] mem_read_data;
  logic [2:0]  dbg_state;

  load_store_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(10)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_size       (req_size),
    .req_unsigned   (req_unsigned),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_write      (mem_write),
    .mem_read       (mem_read),
    .mem_read_data  (mem_read_data),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock / reset / cycle count ----------------
  int cyc = 0;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- data memory seen by the DUT ----------------
  function automatic logic [63:0] seed_word(input int i);
    if (i == 5) return 64'h8877_6655_4433_2211;
    return {32'(i) * 32'h9E37_79B1, ~(32'(i) * 32'h85EB_CA6B)};
  endfunction

  logic [63:0] ram [0:1023];
  bit ram_ready = 1'b0;
  assign mem_read_data = ram[mem_addr];
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 1024; i++) ram[i] <= seed_word(i);
      ram_ready <= 1'b1;
    end else if (mem_write) begin
      ram[mem_addr] <= mem_write_data;
    end
  end

  // ---------------- reference model ----------------
  logic [63:0] ref_mem [0:1023];

  function automatic logic [63:0] model_load(input logic [63:0] w, input int off,
                                             input int nb, input logic uns);
    logic [63:0] v;
    logic [7:0]  b;
    v = '0;
    for (int i = 0; i < nb; i++) begin
      b = 8'(w >> (8 * (off + i)));
      v = v | (64'(b) << (8 * i));
    end
    if (!uns && nb < 8 && v[8*nb-1]) v = v | (~64'd0 << (8 * nb));
    return v;
  endfunction

  function automatic logic [63:0] model_store(input logic [63:0] w, input int off,
                                              input int nb, input logic [63:0] d);
    logic [63:0] r;
    r = w;
    for (int i = 0; i < nb; i++) r[8*(off+i) +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  // exp_q: {cycle[31:0], err, rdata[63:0]}; rd_q: {cycle, word}; wr_q: {cycle, word, data}
  logic [96:0]  exp_q [$];
  logic [41:0]  rd_q  [$];
  logic [105:0] wr_q  [$];
  int busy_lo = -10;
  int busy_hi = -10;
  bit chk_on  = 1'b0;

  typedef struct {
    string       name;
    logic [63:0] act;
    logic [63:0] exp;
  } pin_t;
  pin_t pin_q [$];

  int total = 0;
  int bad   = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int last_resp_cyc = -1;
  logic [63:0] last_rdata = '0;
  logic        last_err = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic pin(input string name, input logic [63:0] act, input logic [63:0] exp);
    pin_t p;
    p.name = name;
    p.act  = act;
    p.exp  = exp;
    pin_q.push_back(p);
  endtask

  logic [96:0]  e_resp;
  logic [41:0]  e_rd;
  logic [105:0] e_wr;
  bit           en;
  pin_t         pp;

  always @(negedge clk) begin
    if (chk_on) begin
      en = exp_q.size() > 0 && exp_q[0][96:65] == 32'(cyc);
      check("resp_valid", 64'(resp_valid), 64'(en));
      if (en) begin
        e_resp = exp_q.pop_front();
        if (resp_valid) begin
          check("resp_rdata", resp_rdata, e_resp[63:0]);
          check("resp_err", 64'(resp_err), 64'(e_resp[64]));
          last_resp_cyc = cyc;
          last_rdata    = resp_rdata;
          last_err      = resp_err;
        end
      end else begin
        check("idle_rdata", resp_rdata, 64'd0);
        check("idle_err", 64'(resp_err), 64'd0);
      end

      en = rd_q.size() > 0 && rd_q[0][41:10] == 32'(cyc);
      check("mem_read", 64'(mem_read), 64'(en));
      if (en) begin
        e_rd = rd_q.pop_front();
        if (mem_read) check("rd_addr", 64'(mem_addr), 64'(e_rd[9:0]));
      end

      en = wr_q.size() > 0 && wr_q[0][105:74] == 32'(cyc);
      check("mem_write", 64'(mem_write), 64'(en));
      if (en) begin
        e_wr = wr_q.pop_front();
        if (mem_write) begin
          check("wr_addr", 64'(mem_addr), 64'(e_wr[73:64]));
          check("wr_data", mem_write_data, e_wr[63:0]);
        end
      end

      check("rd_wr_excl", 64'(mem_read && mem_write), 64'd0);
      check("req_ready", 64'(req_ready), 64'(!(cyc >= busy_lo && cyc <= busy_hi)));
      if (mem_read)  rd_cnt++;
      if (mem_write) wr_cnt++;
    end
    while (pin_q.size() > 0) begin
      pp = pin_q.pop_front();
      check(pp.name, pp.act, pp.exp);
    end
  end

  // ---------------- driver ----------------
  task automatic scramble_inputs();
    req_write    = 1'($urandom);
    req_size     = 2'($urandom);
    req_unsigned = 1'($urandom);
    req_addr     = 13'($urandom);
    req_wdata    = {$urandom, $urandom};
  endtask

  // Called just after a rising edge with the DUT idle; returns with the DUT idle
  // again. acc is the cycle number that starts at the accepting edge.
  task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [12:0] addr, input logic [63:0] wd,
                       input bit abort, output int acc);
    int a, lat, nb, off;
    logic [9:0]  wa;
    logic [63:0] old, nw;
    a   = cyc + 1;
    acc = a;
    nb  = 1 << sz;
    off = int'(addr[2:0]);
    wa  = addr[12:3];
    old = ref_mem[wa];
    req_valid    = 1'b1;
    req_write    = wr;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
    if ((int'(addr) % nb) != 0) begin
      lat = 1;
      exp_q.push_back({32'(a), 1'b1, 64'd0});
    end else if (!wr) begin
      lat = 2;
      rd_q.push_back({32'(a), wa});
      exp_q.push_back({32'(a + 1), 1'b0, model_load(old, off, nb, uns)});
    end else if (nb == 8) begin
      lat = 2;
      wr_q.push_back({32'(a), wa, wd});
      ref_mem[wa] = wd;
      exp_q.push_back({32'(a + 1), 1'b0, 64'd0});
    end else begin
      lat = 3;
      rd_q.push_back({32'(a), wa});
      if (!abort) begin
        nw = model_store(old, off, nb, wd);
        wr_q.push_back({32'(a + 1), wa, nw});
        ref_mem[wa] = nw;
        exp_q.push_back({32'(a + 2), 1'b0, 64'd0});
      end
    end
    busy_lo = a;
    busy_hi = abort ? a : a + lat - 1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    scramble_inputs();
    if (abort) begin
      rst_n = 1'b0;
      @(posedge clk); #1;
      pin("abort_ready", 64'(req_ready), 64'd1);
      rst_n = 1'b1;
    end else begin
      repeat (lat) @(posedge clk);
      #1;
    end
  endtask

  // ---------------- main sequence ----------------
  int acc, r0, w0, mism;
  logic [1:0]  sz;
  logic [9:0]  wa;
  int          nb, off;

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = seed_word(i);
    rst_n     = 1'b0;
    req_valid = 1'b0;
    scramble_inputs();
    repeat (3) @(posedge clk);
    #1;
    pin("rst_ready", 64'(req_ready), 64'd1);
    pin("rst_resp_valid", 64'(resp_valid), 64'd0);
    pin("rst_rdata", resp_rdata, 64'd0);
    pin("rst_err", 64'(resp_err), 64'd0);
    pin("rst_mem_read", 64'(mem_read), 64'd0);
    pin("rst_mem_write", 64'(mem_write), 64'd0);
    pin("rst_mem_addr", 64'(mem_addr), 64'd0);
    pin("rst_mem_wdata", mem_write_data, 64'd0);
    rst_n  = 1'b1;
    chk_on = 1'b1;
    @(posedge clk); #1;

    pin("model_lb", model_load(64'h8877_6655_4433_2211, 7, 1, 1'b0), 64'hFFFF_FFFF_FFFF_FF88);
    pin("model_sb", model_store(64'h8877_6655_4433_2211, 1, 1, 64'hAB), 64'h8877_6655_4433_AB11);

    issue(1'b0, 2'b00, 1'b0, 13'h2F, 64'd0, 1'b0, acc);
    pin("lb_rdata", last_rdata, 64'hFFFF_FFFF_FFFF_FF88);
    pin("lb_latency", 64'(last_resp_cyc - acc + 1), 64'd2);

    issue(1'b0, 2'b01, 1'b1, 13'h2E, 64'd0, 1'b0, acc);
    pin("lhu_rdata", last_rdata, 64'h0000_0000_0000_8877);

    issue(1'b0, 2'b10, 1'b0, 13'h28, 64'd0, 1'b0, acc);
    pin("lw_rdata", last_rdata, 64'h0000_0000_4433_2211);

    w0 = wr_cnt;
    issue(1'b1, 2'b00, 1'b0, 13'h29, 64'h0000_0000_0000_00AB, 1'b0, acc);
    pin("sb_writes", 64'(wr_cnt - w0), 64'd1);
    pin("sb_word5", ram[5], 64'h8877_6655_4433_AB11);
    pin("sb_latency", 64'(last_resp_cyc - acc + 1), 64'd3);

    r0 = rd_cnt; w0 = wr_cnt;
    issue(1'b1, 2'b11, 1'b0, 13'h30, 64'h0123_4567_89AB_CDEF, 1'b0, acc);
    pin("sd_reads", 64'(rd_cnt - r0), 64'd0);
    pin("sd_writes", 64'(wr_cnt - w0), 64'd1);
    pin("sd_word6", ram[6], 64'h0123_4567_89AB_CDEF);
    pin("sd_latency", 64'(last_resp_cyc - acc + 1), 64'd2);

    r0 = rd_cnt; w0 = wr_cnt;
    issue(1'b0, 2'b10, 1'b0, 13'h2A, 64'd0, 1'b0, acc);
    pin("mis_err", 64'(last_err), 64'd1);
    pin("mis_rdata", last_rdata, 64'd0);
    pin("mis_latency", 64'(last_resp_cyc - acc + 1), 64'd1);
    pin("mis_mem_ops", 64'((rd_cnt - r0) + (wr_cnt - w0)), 64'd0);

    w0 = wr_cnt;
    issue(1'b1, 2'b00, 1'b0, 13'h2B, 64'h0000_0000_0000_00CD, 1'b1, acc);
    @(posedge clk); #1;
    pin("abort_writes", 64'(wr_cnt - w0), 64'd0);
    pin("abort_word5", ram[5], 64'h8877_6655_4433_AB11);

    for (int n = 0; n < 300; n++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      sz  = 2'($urandom);
      nb  = 1 << sz;
      wa  = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 7)) : 10'($urandom);
      off = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7))
                                        : nb * int'($urandom_range(0, (8 / nb) - 1));
      issue(1'($urandom), sz, 1'($urandom), {wa, 3'(off)}, {$urandom, $urandom}, 1'b0, acc);
    end

    repeat (2) @(posedge clk);
    #1;
    mism = 0;
    for (int i = 0; i < 1024; i++) if (ram[i] !== ref_mem[i]) mism++;
    pin("final_mem", 64'(mism), 64'd0);
    pin("left_resp", 64'(exp_q.size()), 64'd0);
    pin("left_rd", 64'(rd_q.size()), 64'd0);
    pin("left_wr", 64'(wr_q.size()), 64'd0);
    @(negedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
